// File: rtl/p1v_reset_seq_pkg.sv
// Shared state encodings, reset-cause codes and counter sizing helper for the
// P1V reset sequencer.
package p1v_reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

    localparam logic [1:0] CAUSE_POR  = 2'b01;
    localparam logic [1:0] CAUSE_SOFT = 2'b10;
    localparam logic [1:0] CAUSE_WDT  = 2'b11;

    // Bits needed to hold a counter's terminal value (minimum 1).
    function automatic int unsigned cnt_width(input int unsigned terminal);
        return (terminal < 2) ? 1 : $clog2(terminal + 1);
    endfunction

endpackage

// File: rtl/p1v_reset_seq_if.sv
// Control/status bundle between the reset sequencer and its system-side user.
interface p1v_reset_seq_if #(
    parameter int unsigned NUM_DOMAINS = 2
);
    logic                   soft_rst;
    logic                   wdt_en;
    logic                   wdt_kick;
    logic [NUM_DOMAINS-1:0] nres;
    logic                   rst_busy;
    logic [1:0]             rst_cause;

    modport master (
        output soft_rst, wdt_en, wdt_kick,
        input  nres, rst_busy, rst_cause
    );

    modport slave (
        input  soft_rst, wdt_en, wdt_kick,
        output nres, rst_busy, rst_cause
    );
endinterface

// File: rtl/p1v_resn_sync.sv
// Async-assert, sync-deassert reset synchroniser; reusable in any clock domain.
module p1v_resn_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic sync_rst_n
);

    if (SYNC_STAGES < 2) begin : g_bad_param
        $error("p1v_resn_sync: SYNC_STAGES must be >= 2");
    end

    logic [SYNC_STAGES-1:0] chain_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain_q <= '0;
        else        chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b1};
    end

    assign sync_rst_n = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/p1v_reset_seq.sv
// Reset sequencer: synchronised pin release, power-on hold, staggered domain
// release, software reset request, watchdog, and last-reset-cause record.
module p1v_reset_seq
    import p1v_reset_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 8,
    parameter int unsigned NUM_DOMAINS = 2,
    parameter int unsigned STAGGER     = 4,
    parameter int unsigned WDT_BITS    = 24
) (
    input  logic            clk_cog,
    input  logic            inp_resn,
    p1v_reset_seq_if.slave  bus
);

    if (SYNC_STAGES < 2 || HOLD_CYCLES < 1 || NUM_DOMAINS < 1 ||
        STAGGER < 1 || WDT_BITS < 2) begin : g_bad_param
        $error("p1v_reset_seq: illegal parameter value");
    end

    localparam int unsigned HOLD_W = cnt_width(HOLD_CYCLES - 1);
    localparam int unsigned STG_W  = cnt_width(STAGGER - 1);
    localparam int unsigned DOM_W  = cnt_width(NUM_DOMAINS - 1);

    logic sync_rst_n;

    p1v_resn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk_cog),
        .rst_n      (inp_resn),
        .sync_rst_n (sync_rst_n)
    );

    state_e                 state_q, state_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [STG_W-1:0]       stg_q, stg_d;
    logic [DOM_W-1:0]       dom_q, dom_d;
    logic [WDT_BITS-1:0]    wdt_q, wdt_d;
    logic [NUM_DOMAINS-1:0] nres_q, nres_d;
    logic                   busy_q, busy_d;
    logic [1:0]             cause_q, cause_d;
    logic                   rel_first;
    logic                   rst_req;
    logic [1:0]             req_cause;

    always_ff @(posedge clk_cog or negedge inp_resn) begin
        if (!inp_resn) begin
            state_q <= ST_ASSERT;
            hold_q  <= '0;
            stg_q   <= '0;
            dom_q   <= '0;
            wdt_q   <= '0;
            nres_q  <= '0;
            busy_q  <= 1'b1;
            cause_q <= CAUSE_POR;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            stg_q   <= stg_d;
            dom_q   <= dom_d;
            wdt_q   <= wdt_d;
            nres_q  <= nres_d;
            busy_q  <= busy_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        stg_d     = stg_q;
        dom_d     = dom_q;
        wdt_d     = '0;
        nres_d    = nres_q;
        busy_d    = busy_q;
        cause_d   = cause_q;
        rel_first = 1'b0;
        rst_req   = 1'b0;
        req_cause = CAUSE_SOFT;

        unique case (state_q)
            // The edge that first sees the synchroniser high is hold edge one.
            ST_ASSERT: begin
                if (sync_rst_n) begin
                    if (HOLD_CYCLES == 1) begin
                        rel_first = 1'b1;
                    end else begin
                        state_d = ST_HOLD;
                        hold_d  = HOLD_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (bus.soft_rst)                              hold_d    = '0;
                else if (hold_q == HOLD_W'(HOLD_CYCLES - 1))   rel_first = 1'b1;
                else                                           hold_d    = hold_q + HOLD_W'(1);
            end
            ST_RELEASE: begin
                if (bus.soft_rst) begin
                    rst_req = 1'b1;
                end else if (stg_q == STG_W'(STAGGER - 1)) begin
                    stg_d = '0;
                    for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
                        if (dom_q == DOM_W'(i)) nres_d[i] = 1'b1;
                    end
                    if (dom_q == DOM_W'(NUM_DOMAINS - 1)) begin
                        state_d = ST_RUN;
                        busy_d  = 1'b0;
                    end else begin
                        dom_d = dom_q + DOM_W'(1);
                    end
                end else begin
                    stg_d = stg_q + STG_W'(1);
                end
            end
            ST_RUN: begin
                if (bus.soft_rst) begin
                    rst_req = 1'b1;
                end else if (bus.wdt_en && !bus.wdt_kick) begin
                    if (wdt_q == '1) begin
                        rst_req   = 1'b1;
                        req_cause = CAUSE_WDT;
                    end else begin
                        wdt_d = wdt_q + WDT_BITS'(1);
                    end
                end
            end
        endcase

        // Domain 0 goes first; a single domain skips the stagger phase.
        if (rel_first) begin
            hold_d    = '0;
            nres_d    = '0;
            nres_d[0] = 1'b1;
            stg_d     = '0;
            if (NUM_DOMAINS == 1) begin
                state_d = ST_RUN;
                busy_d  = 1'b0;
            end else begin
                state_d = ST_RELEASE;
                dom_d   = DOM_W'(1);
            end
        end

        if (rst_req) begin
            state_d = ST_HOLD;
            hold_d  = '0;
            stg_d   = '0;
            dom_d   = '0;
            wdt_d   = '0;
            nres_d  = '0;
            busy_d  = 1'b1;
            cause_d = req_cause;
        end
    end

    assign bus.nres      = nres_q;
    assign bus.rst_busy  = busy_q;
    assign bus.rst_cause = cause_q;

endmodule
